// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: WIDTH-bit add/sub computed one nibble per cycle through a 4-bit stage
// Operands shift right each RUN cycle; the result fills from the top so it is aligned after NIB steps.
module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [4:0]       s5;

    always_comb begin
        s5      = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start_valid) begin
                a_d     = a;
                b_d     = op_sub ? ~b : b;
                carry_d = op_sub;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = WIDTH'({s5[3:0], res_q} >> 4);
                carry_d = s5[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    // carry into the MSB differs from carry out exactly on signed overflow
                    cout_d  = s5[4];
                    ovf_d   = a_q[3] ^ b_q[3] ^ s5[3] ^ s5[4];
                    zero_d  = res_d == '0;
                    state_d = DONE;
                end
            end
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign start_ready = state_q == IDLE;
    assign res_valid   = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign result      = res_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
endmodule
